trigger_unit: RTL and testbench
===============================

# trigger_unit

Front-end trigger stage of the 4-channel logic analyzer, sitting directly upstream of `data_path`. It synchronizes the four asynchronous probe inputs, samples them on a sample-rate strobe, and detects a user-selected trigger condition on one channel. On a trigger it raises `start` for exactly `CAPTURE_LEN` samples, so `data_path` records a fixed-length window. It then holds off until the operator re-arms.

## Interface
- `CAPTURE_LEN`, default 256: number of samples per capture window; must be ≥ 2.
- `CNT_W`, default 8: sample counter width; must equal clog2(`CAPTURE_LEN`).
- `clk` input 1: system clock; all logic is on the rising edge.
- `reset` input 1: asynchronous, active-low reset; clears all state when 0.
- `ch_in` input 4: raw probe channels, asynchronous to `clk`.
- `sample_en` input 1: one-cycle sample strobe from the timebase. All sampling and counting advance only on cycles where it is 1.
- `arm` input 1: level; 1 requests arming, and it must return to 0 before re-arming.
- `trig_sel` input 2: channel index used as the trigger source.
- `trig_mode` input 2: trigger condition.
  - 00: rising edge.
  - 01: falling edge.
  - 10: either edge.
  - 11: immediate (free-run).
- `datain` output 4: sampled channel values, feeding `data_path`.
- `start` output 1: 1 for the whole capture window, feeding `data_path` start.
- `armed` output 1: 1 while in ARMED.
- `done` output 1: one-cycle pulse when a capture window ends.

## Operation
- **Synchronizer**
  - `ch_in` passes through a 2-flop synchronizer per bit, giving `sync`.
  - On every `sample_en` cycle, `datain` <= `sync` and `prev` <= `datain`.
- **Edge terms:** evaluated on the selected bit k = `trig_sel`, using `sync[k]` against `datain[k]` (the last sample).
  - rise = !`datain[k]` & `sync[k]`.
  - fall = `datain[k]` & !`sync[k]`.
- **Trigger hit:** `sample_en` & (mode 00: rise; 01: fall; 10: rise|fall; 11: 1).
- **Latched controls:** `trig_sel` and `trig_mode` are latched on the IDLE→ARMED transition. Changes to them while ARMED or in CAPTURE are ignored.
- **FSM states:** IDLE, ARMED, CAPTURE, HOLD.
  - **IDLE:** `arm`=1 → ARMED.
  - **ARMED:**
    - `arm`=0 → IDLE (abort).
    - Otherwise, trigger hit → CAPTURE with cnt <= 0.
    - If a hit and `arm`=0 occur in the same cycle, abort wins.
  - **CAPTURE:**
    - On `sample_en`, cnt <= cnt+1.
    - On `sample_en` with cnt == `CAPTURE_LEN`-1 → HOLD and pulse `done`.
    - `arm` is ignored; a capture always completes.
  - **HOLD:** `arm`=0 → IDLE. No retrigger is possible until `arm` is released and reasserted.
- **Outputs:** registered, driven by state.
  - `start` = (state==CAPTURE).
  - `armed` = (state==ARMED).
- **Counter:** `CNT_W` bits wide; wrap to 0 is never reached because the exit happens at `CAPTURE_LEN`-1.

## Timing
- **Reset values (`reset`=0, immediate):** state IDLE, cnt 0, sync flops 0, `datain` 0, `start` 0, `armed` 0, `done` 0.
- **Reset mid-capture:** `start` drops asynchronously. After release the block is in IDLE, and `arm` must be seen as 1 again to arm.
- **Input latency:** a `ch_in` change reaches `sync` after 2 clk edges and reaches `datain` on the first `sample_en` after that.
- **Arming:** `armed` rises 1 cycle after `arm` is first sampled high in IDLE.
- **Start timing:** `start` rises on the clk edge of the triggering `sample_en` cycle. This is the same edge on which `datain` takes the post-edge value, so the first captured sample is the trigger sample.
- **Start duration:** `start` stays high for exactly `CAPTURE_LEN` `sample_en` strobes, counting the trigger strobe as sample 0. It falls on the edge of strobe `CAPTURE_LEN`, the same edge on which `done`=1 for one cycle.
- **`sample_en` held at 1 continuously:** `start` width is exactly `CAPTURE_LEN` clk cycles.
- **`sample_en` held at 0:** the block freezes in the current state; `datain` and cnt hold.
- **Back-to-back strobes:** a trigger strobe followed by `arm`=0 in the next cycle still yields a full capture.

## Test plan
- **Rising trigger:** `CAPTURE_LEN`=8, `sample_en`=1 constantly, `trig_sel`=2, `trig_mode`=00. Pulse `arm`, then drive `ch_in`[2] 0→1 → `start` high for exactly 8 cycles beginning 3 cycles after the `ch_in` edge, and `done` is a single pulse as `start` falls.
- **Falling trigger with rising-only activity:** `trig_mode`=01 with only rising edges on the selected channel → `start` stays 0 and `armed` stays 1. A falling edge then produces an 8-sample capture.
- **Slow strobe and control latching:** `sample_en` every 4th cycle, `trig_mode`=11 → capture begins on the first strobe after arming, and `start` lasts 32 clk cycles. Changing `trig_sel` mid-capture has no effect.
- **Abort and re-arm:** drop `arm` while ARMED → IDLE with no `start`. Hold `arm`=1 through HOLD → no second capture until `arm` goes 0 then 1.
- **Async reset mid-capture:** assert `reset`=0 at cnt=3 → `start`, `datain` and `done` are 0 within the same cycle. After release with `arm`=0 the block stays IDLE.
- **Either-edge on channel 0:** `trig_mode`=10, `trig_sel`=0. Alternate `ch_in`[0] edges → each re-arm captures on the next edge of either polarity. `datain` matches the synchronized `ch_in` delayed by 2 cycles plus the strobe.

Source files
------------

// File: rtl/trigger_unit.sv
// Logic-analyzer trigger: 2-flop probe sync, strobe sampling, edge/immediate trigger, fixed-length start window.
// Latency: ch_in->datain 2 clk + next sample_en; start rises on the trigger strobe edge. No backpressure; sample_en paces all progress.
module trigger_unit #(
   parameter int CAPTURE_LEN = 256,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] ch_in,
   input  logic       sample_en,
   input  logic       arm,
   input  logic [1:0] trig_sel,
   input  logic [1:0] trig_mode,
   output logic [3:0] datain,
   output logic       start,
   output logic       armed,
   output logic       done
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      HOLD    = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CAPTURE_LEN - 1);

   state_t           state;
   state_t           state_nxt;
   logic [3:0]       sync_meta;
   logic [3:0]       sync;
   logic [1:0]       sel_q;
   logic [1:0]       mode_q;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             rise;
   logic             fall;
   logic             cond;
   logic             hit;
   logic             done_nxt;

   // Probe synchronizer and strobe-gated sample register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_meta <= '0;
         sync      <= '0;
         datain    <= '0;
      end else begin
         sync_meta <= ch_in;
         sync      <= sync_meta;
         if (sample_en) begin
            datain <= sync;
         end
      end
   end

   // Edge is judged between the incoming synchronized value and the last sample taken
   always_comb begin
      rise = 1'b0;
      fall = 1'b0;
      cond = 1'b0;
      rise = ~datain[sel_q] & sync[sel_q];
      fall = datain[sel_q] & ~sync[sel_q];
      case (mode_q)
         2'b00:   cond = rise;
         2'b01:   cond = fall;
         2'b10:   cond = rise | fall;
         default: cond = 1'b1;
      endcase
      hit = sample_en & cond;
   end

   // Trigger controls are frozen at the moment of arming
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sel_q  <= '0;
         mode_q <= '0;
      end else if (state == IDLE && arm) begin
         sel_q  <= trig_sel;
         mode_q <= trig_mode;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         start <= 1'b0;
         armed <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         start <= (state_nxt == CAPTURE);
         armed <= (state_nxt == ARMED);
         done  <= done_nxt;
      end
   end

   // Abort beats a simultaneous hit; a capture in progress ignores arm entirely
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (arm) begin
               state_nxt = ARMED;
            end
         end
         ARMED: begin
            if (!arm) begin
               state_nxt = IDLE;
            end else if (hit) begin
               state_nxt = CAPTURE;
               cnt_nxt   = '0;
            end
         end
         CAPTURE: begin
            if (sample_en) begin
               if (cnt == LAST_CNT) begin
                  state_nxt = HOLD;
                  done_nxt  = 1'b1;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         HOLD: begin
            if (!arm) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_trigger_unit.sv
// Directed bench for trigger_unit with an 8-sample capture window.
// Inputs driven 1 time unit after each rising clock edge; outputs sampled at the same point.
module tb_trigger_unit;

   localparam int LEN = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] ch_in = 4'h0;
   logic       sample_en = 1'b0;
   logic       arm = 1'b0;
   logic [1:0] trig_sel = 2'd0;
   logic [1:0] trig_mode = 2'd0;
   logic [3:0] datain;
   logic       start;
   logic       armed;
   logic       done;

   int n_vec = 0;
   int n_err = 0;
   int div = 1;
   int phase = 0;

   trigger_unit #(.CAPTURE_LEN(LEN), .CNT_W(3)) dut (
      .clk(clk), .reset(reset), .ch_in(ch_in), .sample_en(sample_en), .arm(arm),
      .trig_sel(trig_sel), .trig_mode(trig_mode), .datain(datain), .start(start),
      .armed(armed), .done(done)
   );

   always #5 clk = ~clk;

   // Advance one clock; sample_en is regenerated from div (0 = never, N = every Nth cycle)
   task automatic tick();
      @(posedge clk);
      #1;
      if (div == 0) begin
         sample_en = 1'b0;
      end else begin
         phase = (phase + 1) % div;
         sample_en = (phase == 0);
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_start(input int max, output int cycles);
      cycles = 0;
      while (start !== 1'b1 && cycles < max) begin
         tick();
         cycles++;
      end
   endtask

   // Called right after the edge where start rose
   task automatic measure_window(output int width, output int done_in, output logic done_fall,
                                 output logic done_after);
      width = 1;
      done_in = 0;
      done_fall = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (start === 1'b1) begin
            width++;
            if (done !== 1'b0) done_in++;
         end else begin
            done_fall = done;
            break;
         end
      end
      tick();
      done_after = done;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      div = 1;
      ch_in = 4'hF;
      arm = 1'b1;
      ticks(3);
      n_vec++; if (datain !== 4'h0) begin n_err++; $display("FAIL reset_datain got=%h exp=0", datain); end
      n_vec++; if (start !== 1'b0) begin n_err++; $display("FAIL reset_start got=%b exp=0", start); end
      n_vec++; if (armed !== 1'b0) begin n_err++; $display("FAIL reset_armed got=%b exp=0", armed); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
      arm = 1'b0;
      ch_in = 4'h0;
      ticks(2);
      reset = 1'b1;
      ticks(3);
      n_vec++; if (armed !== 1'b0) begin n_err++; $display("FAIL reset_release_armed got=%b exp=0", armed); end
   endtask

   task automatic test_rise();
      int c, w, din;
      logic df, da;
      trig_sel = 2'd2;
      trig_mode = 2'b00;
      arm = 1'b1;
      tick();
      n_vec++; if (armed !== 1'b1) begin n_err++; $display("FAIL rise_armed got=%b exp=1", armed); end
      ch_in = 4'b0100;
      wait_start(10, c);
      n_vec++; if (c != 3) begin n_err++; $display("FAIL rise_latency got=%0d exp=3", c); end
      n_vec++; if (datain !== 4'b0100) begin n_err++; $display("FAIL rise_datain got=%h exp=4", datain); end
      measure_window(w, din, df, da);
      n_vec++; if (w != LEN) begin n_err++; $display("FAIL rise_width got=%0d exp=%0d", w, LEN); end
      n_vec++; if (df !== 1'b1) begin n_err++; $display("FAIL rise_done_at_fall got=%b exp=1", df); end
      n_vec++; if (din != 0) begin n_err++; $display("FAIL rise_done_early got=%0d exp=0", din); end
      n_vec++; if (da !== 1'b0) begin n_err++; $display("FAIL rise_done_single got=%b exp=0", da); end
      n_vec++; if (armed !== 1'b0) begin n_err++; $display("FAIL rise_hold_armed got=%b exp=0", armed); end
      arm = 1'b0;
      tick();
   endtask

   task automatic test_fall();
      int c, w, din;
      logic df, da;
      trig_sel = 2'd1;
      trig_mode = 2'b01;
      arm = 1'b1;
      tick();
      ch_in[1] = 1'b1;
      ticks(5);
      n_vec++; if (start !== 1'b0) begin n_err++; $display("FAIL fall_norise_start got=%b exp=0", start); end
      n_vec++; if (armed !== 1'b1) begin n_err++; $display("FAIL fall_norise_armed got=%b exp=1", armed); end
      ch_in[1] = 1'b0;
      wait_start(10, c);
      n_vec++; if (c != 3) begin n_err++; $display("FAIL fall_latency got=%0d exp=3", c); end
      n_vec++; if (datain !== 4'b0100) begin n_err++; $display("FAIL fall_datain got=%h exp=4", datain); end
      measure_window(w, din, df, da);
      n_vec++; if (w != LEN) begin n_err++; $display("FAIL fall_width got=%0d exp=%0d", w, LEN); end
      arm = 1'b0;
      tick();
   endtask

   task automatic test_slow_latch();
      int c, w, din;
      logic df, da;
      trig_sel = 2'd0;
      trig_mode = 2'b11;
      div = 4;
      for (int i = 0; i < 8 && sample_en !== 1'b1; i++) tick();
      arm = 1'b1;
      wait_start(20, c);
      n_vec++; if (c != 5) begin n_err++; $display("FAIL slow_first_strobe got=%0d exp=5", c); end
      trig_sel = 2'd3;
      trig_mode = 2'b00;
      measure_window(w, din, df, da);
      n_vec++; if (w != 4 * LEN) begin n_err++; $display("FAIL slow_width got=%0d exp=%0d", w, 4 * LEN); end
      n_vec++; if (df !== 1'b1) begin n_err++; $display("FAIL slow_done_at_fall got=%b exp=1", df); end
      n_vec++; if (da !== 1'b0) begin n_err++; $display("FAIL slow_done_single got=%b exp=0", da); end
   endtask

   task automatic test_abort_rearm();
      int c, w, din, hi;
      logic df, da;
      div = 1;
      hi = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (start !== 1'b0 || armed !== 1'b0) hi++;
      end
      n_vec++; if (hi != 0) begin n_err++; $display("FAIL hold_no_retrigger got=%0d exp=0", hi); end
      arm = 1'b0;
      tick();
      trig_mode = 2'b11;
      arm = 1'b1;
      wait_start(10, c);
      n_vec++; if (c != 2) begin n_err++; $display("FAIL rearm_latency got=%0d exp=2", c); end
      measure_window(w, din, df, da);
      n_vec++; if (w != LEN) begin n_err++; $display("FAIL rearm_width got=%0d exp=%0d", w, LEN); end
      arm = 1'b0;
      tick();
      arm = 1'b1;
      tick();
      n_vec++; if (armed !== 1'b1) begin n_err++; $display("FAIL abort_armed got=%b exp=1", armed); end
      arm = 1'b0;
      tick();
      n_vec++; if (armed !== 1'b0) begin n_err++; $display("FAIL abort_armed_drop got=%b exp=0", armed); end
      n_vec++; if (start !== 1'b0) begin n_err++; $display("FAIL abort_wins got=%b exp=0", start); end
      ticks(3);
      n_vec++; if (start !== 1'b0) begin n_err++; $display("FAIL abort_idle_start got=%b exp=0", start); end
   endtask

   task automatic test_async_reset();
      int c;
      ch_in = 4'b0110;
      ticks(3);
      trig_mode = 2'b11;
      arm = 1'b1;
      wait_start(10, c);
      n_vec++; if (c != 2) begin n_err++; $display("FAIL arst_latency got=%0d exp=2", c); end
      ticks(3);
      n_vec++; if (datain !== 4'b0110) begin n_err++; $display("FAIL arst_pre_datain got=%h exp=6", datain); end
      reset = 1'b0;
      arm = 1'b0;
      #1;
      n_vec++; if (start !== 1'b0) begin n_err++; $display("FAIL arst_start got=%b exp=0", start); end
      n_vec++; if (datain !== 4'h0) begin n_err++; $display("FAIL arst_datain got=%h exp=0", datain); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL arst_done got=%b exp=0", done); end
      #2;
      reset = 1'b1;
      ticks(4);
      n_vec++; if (armed !== 1'b0) begin n_err++; $display("FAIL arst_idle_armed got=%b exp=0", armed); end
      n_vec++; if (start !== 1'b0) begin n_err++; $display("FAIL arst_idle_start got=%b exp=0", start); end
      arm = 1'b1;
      tick();
      n_vec++; if (armed !== 1'b1) begin n_err++; $display("FAIL arst_rearm got=%b exp=1", armed); end
      arm = 1'b0;
      tick();
   endtask

   task automatic test_either_edge();
      int c, w, din;
      logic df, da;
      ch_in = 4'h0;
      ticks(4);
      trig_sel = 2'd0;
      trig_mode = 2'b10;
      for (int r = 0; r < 4; r++) begin
         arm = 1'b1;
         tick();
         ch_in[0] = ~ch_in[0];
         wait_start(10, c);
         n_vec++; if (c != 3) begin n_err++; $display("FAIL either_latency r=%0d got=%0d exp=3", r, c); end
         n_vec++; if (datain[0] !== ch_in[0]) begin n_err++; $display("FAIL either_datain r=%0d got=%b exp=%b", r, datain[0], ch_in[0]); end
         measure_window(w, din, df, da);
         n_vec++; if (w != LEN) begin n_err++; $display("FAIL either_width r=%0d got=%0d exp=%0d", r, w, LEN); end
         arm = 1'b0;
         tick();
      end
   endtask

   task automatic test_back_to_back();
      int w, din;
      logic df, da;
      trig_mode = 2'b11;
      arm = 1'b1;
      ticks(2);
      n_vec++; if (start !== 1'b1) begin n_err++; $display("FAIL b2b_start got=%b exp=1", start); end
      arm = 1'b0;
      measure_window(w, din, df, da);
      n_vec++; if (w != LEN) begin n_err++; $display("FAIL b2b_width got=%0d exp=%0d", w, LEN); end
      n_vec++; if (armed !== 1'b0) begin n_err++; $display("FAIL b2b_idle got=%b exp=0", armed); end
   endtask

   task automatic test_freeze();
      int w, din;
      logic df, da;
      div = 0;
      trig_mode = 2'b11;
      arm = 1'b1;
      tick();
      ch_in = 4'b1011;
      ticks(5);
      n_vec++; if (datain !== 4'h0) begin n_err++; $display("FAIL freeze_datain got=%h exp=0", datain); end
      n_vec++; if (start !== 1'b0) begin n_err++; $display("FAIL freeze_start got=%b exp=0", start); end
      n_vec++; if (armed !== 1'b1) begin n_err++; $display("FAIL freeze_armed got=%b exp=1", armed); end
      div = 1;
      ticks(2);
      n_vec++; if (start !== 1'b1) begin n_err++; $display("FAIL unfreeze_start got=%b exp=1", start); end
      n_vec++; if (datain !== 4'b1011) begin n_err++; $display("FAIL unfreeze_datain got=%h exp=b", datain); end
      arm = 1'b0;
      measure_window(w, din, df, da);
      n_vec++; if (w != LEN) begin n_err++; $display("FAIL unfreeze_width got=%0d exp=%0d", w, LEN); end
   endtask

   initial begin
      test_reset();
      test_rise();
      test_fall();
      test_slow_latch();
      test_abort_rearm();
      test_async_reset();
      test_either_edge();
      test_back_to_back();
      test_freeze();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
